// File: rtl/gx4000_pixel_mixer.sv
// gx4000_pixel_mixer: merges playfield, border and sprite pens through the
// Plus palette RAM into 12-bit RGB, with a fixed 2-cycle pixel pipeline.
// Optional palette readback on cpu_dout is built when MIXER_READBACK_EN is defined.
module gx4000_pixel_mixer #(
    parameter logic [15:0] PAL_BASE = 16'h6400,
    parameter int          LATENCY  = 2
) (
    input  logic        clk_sys,
    input  logic        reset,
    input  logic        plus_mode,
    input  logic        asic_unlocked,
    input  logic [15:0] cpu_addr,
    input  logic [7:0]  cpu_data,
    input  logic        cpu_wr,
    input  logic        cpu_rd,
    output logic [7:0]  cpu_dout,
    input  logic [3:0]  pix_pen,
    input  logic        pix_border,
    input  logic        hblank,
    input  logic        vblank,
    input  logic [7:0]  sprite_pixel,
    input  logic        sprite_active,
    input  logic [11:0] legacy_rgb,
    output logic [11:0] rgb_out,
    output logic        hblank_out,
    output logic        vblank_out
);
    if (LATENCY != 2) begin : g_bad_latency
        $error("gx4000_pixel_mixer: LATENCY must be 2");
    end

    logic [11:0] pal [32];
    logic [15:0] off;
    logic        in_range;
    logic        wr_en;
    logic [4:0]  entry;
    logic        sprite_hit;
    logic [4:0]  idx_next;
    logic        s1_blank;
    logic [4:0]  s1_idx;
    logic [11:0] s1_legacy;
    logic        s1_plus;
    logic        s1_hblank;
    logic        s1_vblank;

    assign off      = cpu_addr - PAL_BASE;
    assign in_range = off < 16'd64;
    assign wr_en    = cpu_wr && asic_unlocked && in_range;
    assign entry    = off[5:1];

    // Palette RAM: even byte carries {R,B}, odd byte carries G in its low nibble.
    always_ff @(posedge clk_sys) begin
        if (reset) begin
            for (int i = 0; i < 32; i++) pal[i] <= '0;
        end else if (wr_en) begin
            if (off[0]) begin
                pal[entry][7:4] <= cpu_data[3:0];
            end else begin
                pal[entry][11:8] <= cpu_data[7:4];
                pal[entry][3:0]  <= cpu_data[3:0];
            end
        end
    end

    // Pen priority: opaque sprite (pen 0 is transparent) over border over playfield.
    always_comb begin
        sprite_hit = sprite_active && (sprite_pixel[3:0] != 4'd0);
        idx_next   = sprite_hit ? {1'b1, sprite_pixel[3:0]} : pix_border ? 5'd16 : {1'b0, pix_pen};
    end

    // Stage 1: latch palette index, blank flag and the legacy path; blanked out of reset.
    always_ff @(posedge clk_sys) begin
        if (reset) begin
            s1_blank  <= 1'b1;
            s1_idx    <= '0;
            s1_legacy <= '0;
            s1_plus   <= 1'b0;
            s1_hblank <= 1'b1;
            s1_vblank <= 1'b1;
        end else begin
            s1_blank  <= hblank | vblank;
            s1_idx    <= idx_next;
            s1_legacy <= legacy_rgb;
            s1_plus   <= plus_mode;
            s1_hblank <= hblank;
            s1_vblank <= vblank;
        end
    end

    // Stage 2: palette lookup or legacy passthrough, with blank flags kept aligned.
    always_ff @(posedge clk_sys) begin
        if (reset) begin
            rgb_out    <= '0;
            hblank_out <= 1'b1;
            vblank_out <= 1'b1;
        end else begin
            rgb_out    <= s1_blank ? 12'h000 : s1_plus ? pal[s1_idx] : s1_legacy;
            hblank_out <= s1_hblank;
            vblank_out <= s1_vblank;
        end
    end

`ifdef MIXER_READBACK_EN
    logic unused;
    assign unused = ^sprite_pixel[7:4];

    // Readback holds the last in-range read; the lock does not apply to reads.
    always_ff @(posedge clk_sys) begin
        if (reset)
            cpu_dout <= '0;
        else if (cpu_rd && in_range)
            cpu_dout <= off[0] ? {4'h0, pal[entry][7:4]} : {pal[entry][11:8], pal[entry][3:0]};
    end
`else
    logic unused;
    assign unused   = ^{sprite_pixel[7:4], cpu_rd};
    assign cpu_dout = 8'h00;
`endif
endmodule

// File: tb/tb_gx4000_pixel_mixer.sv
// tb_gx4000_pixel_mixer: randomized scoreboard bench against a nibble-level palette model.
module tb_gx4000_pixel_mixer;
    localparam int PB = 'h6400;

    logic        clk_sys = 0;
    logic        reset = 1;
    logic        plus_mode = 0;
    logic        asic_unlocked = 0;
    logic [15:0] cpu_addr = 0;
    logic [7:0]  cpu_data = 0;
    logic        cpu_wr = 0;
    logic        cpu_rd = 0;
    logic [7:0]  cpu_dout;
    logic [3:0]  pix_pen = 0;
    logic        pix_border = 0;
    logic        hblank = 0;
    logic        vblank = 0;
    logic [7:0]  sprite_pixel = 0;
    logic        sprite_active = 0;
    logic [11:0] legacy_rgb = 0;
    logic [11:0] rgb_out;
    logic        hblank_out;
    logic        vblank_out;

    gx4000_pixel_mixer dut (
        .clk_sys(clk_sys), .reset(reset), .plus_mode(plus_mode), .asic_unlocked(asic_unlocked),
        .cpu_addr(cpu_addr), .cpu_data(cpu_data), .cpu_wr(cpu_wr), .cpu_rd(cpu_rd),
        .cpu_dout(cpu_dout), .pix_pen(pix_pen), .pix_border(pix_border), .hblank(hblank),
        .vblank(vblank), .sprite_pixel(sprite_pixel), .sprite_active(sprite_active),
        .legacy_rgb(legacy_rgb), .rgb_out(rgb_out), .hblank_out(hblank_out), .vblank_out(vblank_out)
    );

    always #5 clk_sys = ~clk_sys;

    typedef struct { logic [11:0] rgb; logic hb; logic vb; int due; } pix_t;
    typedef struct { logic [7:0] d; int due; } rd_t;
    pix_t q[$];
    rd_t  dq[$];
    int   cyc = 0;
    int   n_checks = 0;
    int   n_fail = 0;

    int   mr[32], mg[32], mb[32];
    logic [7:0] mdout;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, got, exp, cyc);
        end
    endtask

    always @(posedge clk_sys) begin
        pix_t p;
        rd_t  r;
        cyc++;
        #1;
        while (q.size() > 0 && q[0].due <= cyc) begin
            p = q.pop_front();
            chk("rgb_out", {20'd0, rgb_out}, {20'd0, p.rgb});
            chk("hblank_out", {31'd0, hblank_out}, {31'd0, p.hb});
            chk("vblank_out", {31'd0, vblank_out}, {31'd0, p.vb});
        end
        while (dq.size() > 0 && dq[0].due <= cyc) begin
            r = dq.pop_front();
            chk("cpu_dout", {24'd0, cpu_dout}, {24'd0, r.d});
        end
    end

    task automatic tick();
        int a, e, pen;
        logic in_rng;
        logic [11:0] exp;
        a = int'(cpu_addr);
        in_rng = a >= PB && a <= PB + 63;
        e = (a - PB) / 2;
`ifdef MIXER_READBACK_EN
        if (cpu_rd && in_rng)
            mdout = (a % 2 == 1) ? 8'(mg[e]) : 8'(mr[e] * 16 + mb[e]);
`endif
        if (cpu_wr && asic_unlocked && in_rng) begin
            if (a % 2 == 1) mg[e] = cpu_data % 16;
            else begin
                mr[e] = cpu_data / 16;
                mb[e] = cpu_data % 16;
            end
        end
        if (sprite_active && sprite_pixel % 16 != 0) pen = 16 + sprite_pixel % 16;
        else if (pix_border) pen = 16;
        else pen = pix_pen;
        if (hblank || vblank) exp = 0;
        else if (!plus_mode) exp = legacy_rgb;
        else exp = 12'(mr[pen] * 256 + mg[pen] * 16 + mb[pen]);
        q.push_back('{exp, hblank, vblank, cyc + 2});
        dq.push_back('{mdout, cyc + 1});
        @(negedge clk_sys);
    endtask

    task automatic do_reset(input int n);
        reset = 1;
        q.delete();
        dq.delete();
        mdout = 0;
        for (int i = 0; i < 32; i++) begin mr[i] = 0; mg[i] = 0; mb[i] = 0; end
        repeat (n) @(negedge clk_sys);
        chk("reset rgb_out", {20'd0, rgb_out}, 0);
        chk("reset hblank_out", {31'd0, hblank_out}, 1);
        chk("reset vblank_out", {31'd0, vblank_out}, 1);
        chk("reset cpu_dout", {24'd0, cpu_dout}, 0);
        reset = 0;
    endtask

    task automatic wr(input logic [15:0] a, input logic [7:0] d);
        cpu_addr = a; cpu_data = d; cpu_wr = 1;
        tick();
        cpu_wr = 0;
    endtask

    task automatic settle();
        tick();
        tick();
    endtask

    initial begin
        @(negedge clk_sys);
        do_reset(3);
        plus_mode = 1;
        settle();
        chk("idle pen0", {20'd0, rgb_out}, 12'h000);
        asic_unlocked = 1;
        wr(16'h6402, 8'hF5);
        wr(16'h6403, 8'h3A);
        pix_pen = 1;
        settle();
        chk("entry1 colour", {20'd0, rgb_out}, 12'hFA5);
        asic_unlocked = 0;
        wr(16'h6402, 8'h00);
        settle();
        chk("locked write ignored", {20'd0, rgb_out}, 12'hFA5);
        asic_unlocked = 1;
        wr(16'h6420, 8'h00);
        wr(16'h6421, 8'h0F);
        wr(16'h6426, 8'h0F);
        wr(16'h6427, 8'h00);
        pix_border = 1; sprite_active = 1; sprite_pixel = 8'h03;
        settle();
        chk("sprite over border", {20'd0, rgb_out}, 12'h00F);
        sprite_pixel = 8'h00;
        settle();
        chk("sprite pen0 transparent", {20'd0, rgb_out}, 12'h0F0);
        sprite_active = 0; pix_border = 0; pix_pen = 1;
        settle();
        chk("playfield pen1", {20'd0, rgb_out}, 12'hFA5);
        plus_mode = 0; legacy_rgb = 12'h123;
        settle();
        chk("legacy passthrough", {20'd0, rgb_out}, 12'h123);
        hblank = 1;
        tick();
        chk("hblank one deep", {20'd0, rgb_out}, 12'h123);
        tick();
        chk("hblank colour", {20'd0, rgb_out}, 12'h000);
        chk("hblank_out", {31'd0, hblank_out}, 1);
        hblank = 0;
`ifdef MIXER_READBACK_EN
        cpu_rd = 1; cpu_addr = 16'h6402;
        tick();
        cpu_rd = 0;
        chk("readback even", {24'd0, cpu_dout}, 8'hF5);
        cpu_rd = 1; cpu_addr = 16'h6403;
        tick();
        cpu_rd = 0;
        chk("readback odd", {24'd0, cpu_dout}, 8'h0A);
`endif
        for (int i = 0; i < 3000; i++) begin
            cpu_addr      = ($urandom_range(9) == 0) ? 16'($urandom) : 16'($urandom_range(16'h6448, 16'h63F8));
            cpu_data      = 8'($urandom);
            cpu_wr        = $urandom_range(2) == 0;
            cpu_rd        = $urandom_range(2) == 0;
            asic_unlocked = $urandom_range(3) != 0;
            if ($urandom_range(15) == 0) plus_mode = ~plus_mode;
            pix_pen       = 4'($urandom);
            pix_border    = $urandom_range(3) == 0;
            hblank        = $urandom_range(9) == 0;
            vblank        = $urandom_range(19) == 0;
            sprite_pixel  = 8'($urandom);
            sprite_active = $urandom_range(1) == 0;
            legacy_rgb    = 12'($urandom);
            if (i == 1500) begin
                cpu_wr = 0;
                do_reset(2);
            end
            tick();
        end
        cpu_wr = 0; cpu_rd = 0;
        for (int i = 0; i < 10 && (q.size() > 0 || dq.size() > 0); i++) @(negedge clk_sys);
        if (q.size() > 0 || dq.size() > 0) begin
            n_fail++;
            $display("FAIL drain: %0d pixel and %0d readback expectations left, required 0", q.size(), dq.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
